// File: rtl/serial_sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and
// the sizing rule for the bit counter.
package serial_sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  // Bits needed to count 0..width-1; never less than one.
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: d = (a - b) mod 2^WIDTH, one bit per clock,
// LSB first; bo flags a < b. Results are published only once complete.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_subtractor: WIDTH out of range");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-2:0] w_res_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bin;
  logic [WIDTH-1:0] r_d;
  logic             r_bo;
  logic             w_diff;
  logic             w_bout;
  logic             w_accept;
  logic             w_last;

  full_subtractor u_full_subtractor (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_bin),
    .d    (w_diff),
    .bout (w_bout)
  );

  assign w_accept = (r_state == ST_IDLE) && start;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_state_next = ST_RUN;
      ST_RUN:  if (r_cnt == CNT_LAST) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result bits enter at the top and drift down; after WIDTH-1 bits the
  // register holds the low bits in place and the final bit is appended on load.
  always_comb begin
    w_res_next = '0;
    for (int i = 0; i < int'(WIDTH) - 2; i++) begin
      w_res_next[i] = r_res[i+1];
    end
    w_res_next[WIDTH-2] = w_diff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_cnt <= '0;
      r_bin <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_res <= '0;
      r_cnt <= '0;
      r_bin <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_res_next;
      r_cnt <= r_cnt + CNT_W'(1);
      r_bin <= w_bout;
    end
  end

  // Published result only changes on the final bit edge, so it never shows partials.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d  <= '0;
      r_bo <= 1'b0;
    end else if (w_last) begin
      r_d  <= {w_diff, r_res};
      r_bo <= w_bout;
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign d    = r_d;
  assign bo   = r_bo;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port start, input, 1, request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a, input, WIDTH, minuend (unsigned); captured on the accepting edge.
REQ-006 SHALL have port b, input, WIDTH, subtrahend (unsigned); captured on the accepting edge.
REQ-007 SHALL have port busy, output, 1, high while an operation is in progress (RUN state).
REQ-008 SHALL have port done, output, 1, single-cycle pulse marking a valid result.
REQ-009 SHALL have port d, output, WIDTH, difference (a-b) mod 2^WIDTH.
REQ-010 SHALL have port bo, output, 1, borrow out; 1 iff a < b unsigned.

Function
REQ-011 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on an edge with start=1; RUN->DONE after WIDTH RUN edges; DONE->IDLE unconditionally after one cycle.
REQ-012 SHALL, on the accepting edge, latch a and b into internal shift registers, clear the borrow flop to 0 and clear the bit counter to 0.
REQ-013 SHALL, on each RUN edge, process one bit LSB first: diff bit = a_i ^ b_i ^ bin; new borrow = (~a_i & b_i) | (~a_i & bin) | (b_i & bin); shift the bit into an internal result register; increment the counter.
REQ-014 SHALL move to DONE on the RUN edge processing bit WIDTH-1, loading d from the internal result register and bo from the final borrow on that same edge.
REQ-015 SHALL assert done for exactly the one cycle following the WIDTH-th rising edge after the accepting edge (latency WIDTH cycles); busy low in that cycle.
REQ-016 SHALL hold d and bo stable from the DONE transition until the next DONE transition; d and bo never show partial results.
REQ-017 SHALL ignore start in RUN and DONE; a and b changes after the accepting edge do not affect the result.
REQ-018 SHALL accept start held continuously high as back-to-back operations: next acceptance on the first IDLE edge after DONE (throughput one result per WIDTH+2 cycles).
REQ-019 SHALL keep busy=1 exactly in RUN, done=1 exactly in DONE.

Reset
REQ-020 SHALL, while rst_n=0, force state IDLE, busy=0, done=0, d=0, bo=0, counter=0, borrow=0, independent of clk.
REQ-021 SHALL, on reset asserted mid-RUN or in DONE, abandon the operation with no done pulse; first start after rst_n deasserts is processed normally.

Structure
REQ-022 SHALL take state encoding constants (IDLE, RUN, DONE) and counter-width derivation from shared package serial_sub_pkg.
REQ-023 SHALL instantiate one combinational sub-module full_subtractor (inputs a, b, bin; outputs d, bout) for the per-bit datapath.

Verification (WIDTH=4)
REQ-024 a=9, b=3, start one cycle -> busy high 4 cycles, done pulse in the following cycle, d=6, bo=0.
REQ-025 a=3, b=9 -> d=10, bo=1; a=0, b=1 -> d=15, bo=1 (borrow ripples through all bits).
REQ-026 a=15, b=15 and a=0, b=0 -> d=0, bo=0 each; exhaustive 256-pair sweep matches (a-b) mod 16 and a<b.
REQ-027 start pulsed again during RUN with a=1, b=1 -> ignored; result of first operation (a=9, b=3: d=6) reported, single done.
REQ-028 start held high with a=7, b=2 -> repeated done pulses every 6 cycles, d=5, bo=0 each time.
REQ-029 rst_n low at 2nd RUN cycle -> busy=0, done=0, d=0, bo=0 immediately; no done; following a=5, b=8 -> d=13, bo=1.
